// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared constants and types for the multicycle MIPS control unit:
// opcodes, funct codes, ALU control encodings, state and alu_op encodings.
package multicycle_ctrl_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXEC     = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_IMMEXEC  = 4'd9,
        ST_IMMWB    = 4'd10,
        ST_JUMP     = 4'd11,
        ST_TRAP     = 4'd12
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2,
        ALUOP_IMM   = 2'd3
    } alu_op_e;

    // Unknown funct codes fall back to ADD so the ALU control is never undefined.
    function automatic logic [2:0] funct_to_alu(input logic [5:0] funct);
        logic [2:0] res;
        case (funct)
            FN_ADD:  res = ALU_ADD;
            FN_SUB:  res = ALU_SUB;
            FN_AND:  res = ALU_AND;
            FN_OR:   res = ALU_OR;
            FN_SLT:  res = ALU_SLT;
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

    function automatic logic [2:0] imm_op_to_alu(input logic [5:0] op);
        logic [2:0] res;
        case (op)
            OP_ADDI: res = ALU_ADD;
            OP_ANDI: res = ALU_AND;
            OP_ORI:  res = ALU_OR;
            OP_SLTI: res = ALU_SLT;
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_ctrl_decoder.sv
// Combinational ALU control decoder: {alu_op, registered opcode, funct} -> ALU control.
module multicycle_ctrl_fsm_alu_ctrl_decoder
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int OP_WIDTH_P        = 6,
    parameter int FUNCT_WIDTH_P     = 6,
    parameter int ALU_CNTRL_WIDTH_P = 3
) (
    input  alu_op_e                      alu_op_i,
    input  logic [OP_WIDTH_P-1:0]        op_i,
    input  logic [FUNCT_WIDTH_P-1:0]     funct_i,
    output logic [ALU_CNTRL_WIDTH_P-1:0] alu_cntrl_o
);

    logic [2:0] alu_s;

    // Select the ALU operation source according to the state's alu_op class.
    always_comb begin
        alu_s = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD:   alu_s = ALU_ADD;
            ALUOP_SUB:   alu_s = ALU_SUB;
            ALUOP_FUNCT: alu_s = funct_to_alu(6'(funct_i));
            ALUOP_IMM:   alu_s = imm_op_to_alu(6'(op_i));
            default:     alu_s = ALU_ADD;
        endcase
        alu_cntrl_o = ALU_CNTRL_WIDTH_P'(alu_s);
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control FSM with memory req/ready wait states.
// Optional macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes park in TRAP and drive o_trap.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int OP_WIDTH_P        = 6,
    parameter int FUNCT_WIDTH_P     = 6,
    parameter int ALU_CNTRL_WIDTH_P = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [OP_WIDTH_P-1:0]        i_opcode,
    input  logic [FUNCT_WIDTH_P-1:0]     i_function,
    input  logic                         i_mem_ready,
    output logic                         o_mem_req,
    output logic                         o_mem_wr_en,
    output logic                         o_mem_addr_sel,
    output logic                         o_instr_wr_en,
    output logic                         o_pc_en,
    output logic                         o_branch,
    output logic                         o_branch_ne,
    output logic [1:0]                   o_pc_next_sel,
    output logic                         o_alu_src_a_sel,
    output logic [1:0]                   o_alu_src_b_sel,
    output logic                         o_imm_zero_ext,
    output logic [ALU_CNTRL_WIDTH_P-1:0] o_alu_cntrl,
    output logic                         o_reg_wr_en,
    output logic                         o_reg_wr_addr_sel,
    output logic                         o_reg_wr_data_sel,
    output logic                         o_instr_retire,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic                         o_trap,
`endif
    output logic [3:0]                   o_state
);

    localparam logic [OP_WIDTH_P-1:0] OPC_RTYPE = OP_WIDTH_P'(OP_RTYPE);
    localparam logic [OP_WIDTH_P-1:0] OPC_J     = OP_WIDTH_P'(OP_J);
    localparam logic [OP_WIDTH_P-1:0] OPC_BEQ   = OP_WIDTH_P'(OP_BEQ);
    localparam logic [OP_WIDTH_P-1:0] OPC_BNE   = OP_WIDTH_P'(OP_BNE);
    localparam logic [OP_WIDTH_P-1:0] OPC_ADDI  = OP_WIDTH_P'(OP_ADDI);
    localparam logic [OP_WIDTH_P-1:0] OPC_SLTI  = OP_WIDTH_P'(OP_SLTI);
    localparam logic [OP_WIDTH_P-1:0] OPC_ANDI  = OP_WIDTH_P'(OP_ANDI);
    localparam logic [OP_WIDTH_P-1:0] OPC_ORI   = OP_WIDTH_P'(OP_ORI);
    localparam logic [OP_WIDTH_P-1:0] OPC_LW    = OP_WIDTH_P'(OP_LW);
    localparam logic [OP_WIDTH_P-1:0] OPC_SW    = OP_WIDTH_P'(OP_SW);

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_e ILLEGAL_TGT = ST_TRAP;
`else
    localparam state_e ILLEGAL_TGT = ST_FETCH;
`endif

    state_e                  state_q;
    logic [OP_WIDTH_P-1:0]   op_q;
    alu_op_e                 alu_op_s;

    function automatic state_e decode_target(input logic [OP_WIDTH_P-1:0] op);
        state_e tgt;
        if (op == OPC_RTYPE) begin
            tgt = ST_EXEC;
        end else if ((op == OPC_LW) || (op == OPC_SW)) begin
            tgt = ST_MEMADR;
        end else if ((op == OPC_BEQ) || (op == OPC_BNE)) begin
            tgt = ST_BRANCH;
        end else if ((op == OPC_ADDI) || (op == OPC_ANDI) ||
                     (op == OPC_ORI)  || (op == OPC_SLTI)) begin
            tgt = ST_IMMEXEC;
        end else if (op == OPC_J) begin
            tgt = ST_JUMP;
        end else begin
            tgt = ILLEGAL_TGT;
        end
        return tgt;
    endfunction

    // State register and opcode latch; the opcode is captured only in DECODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (i_mem_ready) begin
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    op_q    <= i_opcode;
                    state_q <= decode_target(i_opcode);
                end
                ST_MEMADR:   state_q <= (op_q == OPC_LW) ? ST_MEMREAD : ST_MEMWRITE;
                ST_MEMREAD: begin
                    if (i_mem_ready) begin
                        state_q <= ST_MEMWB;
                    end
                end
                ST_MEMWB:    state_q <= ST_FETCH;
                ST_MEMWRITE: begin
                    if (i_mem_ready) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_EXEC:     state_q <= ST_ALUWB;
                ST_ALUWB:    state_q <= ST_FETCH;
                ST_BRANCH:   state_q <= ST_FETCH;
                ST_IMMEXEC:  state_q <= ST_IMMWB;
                ST_IMMWB:    state_q <= ST_FETCH;
                ST_JUMP:     state_q <= ST_FETCH;
                ST_TRAP:     state_q <= ILLEGAL_TGT;
                default:     state_q <= ST_FETCH;
            endcase
        end
    end

    // Datapath control decode; reset forces every enable low so an in-flight access aborts at once.
    always_comb begin
        o_mem_req         = 1'b0;
        o_mem_wr_en       = 1'b0;
        o_mem_addr_sel    = 1'b0;
        o_instr_wr_en     = 1'b0;
        o_pc_en           = 1'b0;
        o_branch          = 1'b0;
        o_branch_ne       = 1'b0;
        o_pc_next_sel     = 2'b00;
        o_alu_src_a_sel   = 1'b0;
        o_alu_src_b_sel   = 2'b00;
        o_imm_zero_ext    = 1'b0;
        o_reg_wr_en       = 1'b0;
        o_reg_wr_addr_sel = 1'b0;
        o_reg_wr_data_sel = 1'b0;
        o_instr_retire    = 1'b0;
        alu_op_s          = ALUOP_ADD;
`ifdef CTRL_ILLEGAL_TRAP_EN
        o_trap            = 1'b0;
`endif
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    o_mem_req       = 1'b1;
                    o_alu_src_b_sel = 2'b01;
                    o_instr_wr_en   = i_mem_ready;
                    o_pc_en         = i_mem_ready;
                end
                ST_DECODE: o_alu_src_b_sel = 2'b11;
                ST_MEMADR: begin
                    o_alu_src_a_sel = 1'b1;
                    o_alu_src_b_sel = 2'b10;
                end
                ST_MEMREAD: begin
                    o_mem_req      = 1'b1;
                    o_mem_addr_sel = 1'b1;
                end
                ST_MEMWB: begin
                    o_reg_wr_en       = 1'b1;
                    o_reg_wr_data_sel = 1'b1;
                    o_instr_retire    = 1'b1;
                end
                ST_MEMWRITE: begin
                    o_mem_req      = 1'b1;
                    o_mem_wr_en    = 1'b1;
                    o_mem_addr_sel = 1'b1;
                    o_instr_retire = i_mem_ready;
                end
                ST_EXEC: begin
                    o_alu_src_a_sel = 1'b1;
                    alu_op_s        = ALUOP_FUNCT;
                end
                ST_ALUWB: begin
                    o_reg_wr_en       = 1'b1;
                    o_reg_wr_addr_sel = 1'b1;
                    o_instr_retire    = 1'b1;
                end
                ST_BRANCH: begin
                    o_alu_src_a_sel = 1'b1;
                    alu_op_s        = ALUOP_SUB;
                    o_pc_next_sel   = 2'b01;
                    o_branch        = (op_q == OPC_BEQ);
                    o_branch_ne     = (op_q == OPC_BNE);
                    o_instr_retire  = 1'b1;
                end
                ST_IMMEXEC: begin
                    o_alu_src_a_sel = 1'b1;
                    o_alu_src_b_sel = 2'b10;
                    o_imm_zero_ext  = (op_q == OPC_ANDI) || (op_q == OPC_ORI);
                    alu_op_s        = ALUOP_IMM;
                end
                ST_IMMWB: begin
                    o_reg_wr_en    = 1'b1;
                    o_instr_retire = 1'b1;
                end
                ST_JUMP: begin
                    o_pc_en        = 1'b1;
                    o_pc_next_sel  = 2'b10;
                    o_instr_retire = 1'b1;
                end
                ST_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    o_trap = 1'b1;
`else
                    o_instr_retire = 1'b0;
`endif
                end
                default: o_instr_retire = 1'b0;
            endcase
        end else begin
            alu_op_s = ALUOP_ADD;
        end
    end

    assign o_state = state_q;

    multicycle_ctrl_fsm_alu_ctrl_decoder #(
        .OP_WIDTH_P        (OP_WIDTH_P),
        .FUNCT_WIDTH_P     (FUNCT_WIDTH_P),
        .ALU_CNTRL_WIDTH_P (ALU_CNTRL_WIDTH_P)
    ) u_alu_ctrl_decoder (
        .alu_op_i    (alu_op_s),
        .op_i        (op_q),
        .funct_i     (i_function),
        .alu_cntrl_o (o_alu_cntrl)
    );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench: instruction-level model expands each instruction into per-cycle expected controls.
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic       mem_req;
        logic       mem_wr_en;
        logic       addr_sel;
        logic       instr_wr_en;
        logic       pc_en;
        logic       branch;
        logic       branch_ne;
        logic [1:0] pc_next_sel;
        logic       src_a;
        logic [1:0] src_b;
        logic       zext;
        logic [2:0] alu;
        logic       reg_wr_en;
        logic       wr_addr_sel;
        logic       wr_data_sel;
        logic       retire;
        logic       trap;
    } ctl_t;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic [5:0] op;
        logic [5:0] fn;
        ctl_t       exp;
        int         id;
    } vec_t;

    localparam logic [5:0] JUNK_OP = 6'b111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] i_opcode = 6'b000000;
    logic [5:0] i_function = 6'b000000;
    logic       i_mem_ready = 1'b0;
    logic       o_mem_req, o_mem_wr_en, o_mem_addr_sel, o_instr_wr_en, o_pc_en;
    logic       o_branch, o_branch_ne, o_alu_src_a_sel, o_imm_zero_ext;
    logic [1:0] o_pc_next_sel, o_alu_src_b_sel;
    logic [2:0] o_alu_cntrl;
    logic       o_reg_wr_en, o_reg_wr_addr_sel, o_reg_wr_data_sel, o_instr_retire;
    logic [3:0] o_state;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       o_trap;
`endif

    vec_t vq[$];
    int   cur_id = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    int   n_retire = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm dut (
        .clk               (clk),
        .reset             (reset),
        .i_opcode          (i_opcode),
        .i_function        (i_function),
        .i_mem_ready       (i_mem_ready),
        .o_mem_req         (o_mem_req),
        .o_mem_wr_en       (o_mem_wr_en),
        .o_mem_addr_sel    (o_mem_addr_sel),
        .o_instr_wr_en     (o_instr_wr_en),
        .o_pc_en           (o_pc_en),
        .o_branch          (o_branch),
        .o_branch_ne       (o_branch_ne),
        .o_pc_next_sel     (o_pc_next_sel),
        .o_alu_src_a_sel   (o_alu_src_a_sel),
        .o_alu_src_b_sel   (o_alu_src_b_sel),
        .o_imm_zero_ext    (o_imm_zero_ext),
        .o_alu_cntrl       (o_alu_cntrl),
        .o_reg_wr_en       (o_reg_wr_en),
        .o_reg_wr_addr_sel (o_reg_wr_addr_sel),
        .o_reg_wr_data_sel (o_reg_wr_data_sel),
        .o_instr_retire    (o_instr_retire),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .o_trap            (o_trap),
`endif
        .o_state           (o_state)
    );

    function automatic ctl_t idle();
        ctl_t c;
        c = '0;
        c.alu = 3'b010;
        return c;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [2:0] imm_alu(input logic [5:0] op);
        case (op)
            6'b001100: return 3'b000;
            6'b001101: return 3'b001;
            6'b001010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    task automatic push(input logic rst, input logic rdy, input logic [5:0] op,
                        input logic [5:0] fn, input ctl_t e);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.op = op; v.fn = fn; v.exp = e; v.id = cur_id;
        vq.push_back(v);
    endtask

    task automatic push_reset(input int cycles);
        for (int i = 0; i < cycles; i++) push(1'b1, 1'b1, JUNK_OP, 6'b000000, idle());
    endtask

    // Expand one instruction into its expected cycle sequence; abort_mem injects reset in a memory wait.
    task automatic add_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input bit abort_mem);
        ctl_t c;
        bit   is_mem;
        cur_id++;
        c = idle(); c.mem_req = 1'b1; c.src_b = 2'b01;
        for (int i = 0; i < fw; i++) push(1'b0, 1'b0, JUNK_OP, fn, c);
        c.instr_wr_en = 1'b1; c.pc_en = 1'b1;
        push(1'b0, 1'b1, JUNK_OP, fn, c);
        c = idle(); c.src_b = 2'b11;
        push(1'b0, 1'b1, op, fn, c);
        is_mem = (op == 6'b100011) || (op == 6'b101011);
        if (is_mem) begin
            c = idle(); c.src_a = 1'b1; c.src_b = 2'b10;
            push(1'b0, 1'b1, JUNK_OP, fn, c);
            c = idle(); c.mem_req = 1'b1; c.addr_sel = 1'b1; c.mem_wr_en = (op == 6'b101011);
            for (int i = 0; i < mw; i++) push(1'b0, 1'b0, JUNK_OP, fn, c);
            if (abort_mem) begin
                push_reset(1);
            end else begin
                c.retire = (op == 6'b101011);
                push(1'b0, 1'b1, JUNK_OP, fn, c);
                if (op == 6'b100011) begin
                    c = idle(); c.reg_wr_en = 1'b1; c.wr_data_sel = 1'b1; c.retire = 1'b1;
                    push(1'b0, 1'b1, JUNK_OP, fn, c);
                end
            end
        end else if (op == 6'b000000) begin
            c = idle(); c.src_a = 1'b1; c.alu = funct_alu(fn);
            push(1'b0, 1'b1, JUNK_OP, fn, c);
            c = idle(); c.reg_wr_en = 1'b1; c.wr_addr_sel = 1'b1; c.retire = 1'b1;
            push(1'b0, 1'b1, JUNK_OP, fn, c);
        end else if ((op == 6'b000100) || (op == 6'b000101)) begin
            c = idle(); c.src_a = 1'b1; c.alu = 3'b110; c.pc_next_sel = 2'b01; c.retire = 1'b1;
            c.branch = (op == 6'b000100); c.branch_ne = (op == 6'b000101);
            push(1'b0, 1'b1, JUNK_OP, fn, c);
        end else if ((op == 6'b001000) || (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001010)) begin
            c = idle(); c.src_a = 1'b1; c.src_b = 2'b10; c.alu = imm_alu(op);
            c.zext = (op == 6'b001100) || (op == 6'b001101);
            push(1'b0, 1'b1, JUNK_OP, fn, c);
            c = idle(); c.reg_wr_en = 1'b1; c.retire = 1'b1;
            push(1'b0, 1'b1, JUNK_OP, fn, c);
        end else if (op == 6'b000010) begin
            c = idle(); c.pc_en = 1'b1; c.pc_next_sel = 2'b10; c.retire = 1'b1;
            push(1'b0, 1'b1, JUNK_OP, fn, c);
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            c = idle(); c.trap = 1'b1;
            for (int i = 0; i < 3; i++) push(1'b0, 1'b1, JUNK_OP, fn, c);
            push_reset(1);
`else
            c = idle();
`endif
        end
    endtask

    // Hand-written vectors for a FETCH with three wait cycles followed by a jump.
    task automatic add_literal_fetch_jump();
        ctl_t c;
        cur_id++;
        c = '0; c.mem_req = 1'b1; c.src_b = 2'b01; c.alu = 3'b010;
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, JUNK_OP, 6'b000000, c);
        c.instr_wr_en = 1'b1; c.pc_en = 1'b1;
        push(1'b0, 1'b1, JUNK_OP, 6'b000000, c);
        c = '0; c.src_b = 2'b11; c.alu = 3'b010;
        push(1'b0, 1'b0, 6'b000010, 6'b000000, c);
        c = '0; c.pc_en = 1'b1; c.pc_next_sel = 2'b10; c.retire = 1'b1; c.alu = 3'b010;
        push(1'b0, 1'b0, JUNK_OP, 6'b000000, c);
    endtask

    initial begin
        vec_t v;
        ctl_t act;
        push_reset(2);
        add_literal_fetch_jump();
        add_instr(6'b100011, 6'b000000, 0, 0, 1'b0);
        add_instr(6'b101011, 6'b000000, 0, 2, 1'b0);
        add_instr(6'b000000, 6'b101010, 0, 0, 1'b0);
        add_instr(6'b000101, 6'b000000, 0, 0, 1'b0);
        add_instr(6'b001101, 6'b000000, 0, 0, 1'b0);
        add_instr(6'b000000, 6'b100000, 1, 0, 1'b0);
        add_instr(6'b000000, 6'b100010, 0, 0, 1'b0);
        add_instr(6'b000000, 6'b100100, 0, 0, 1'b0);
        add_instr(6'b000000, 6'b100101, 0, 0, 1'b0);
        add_instr(6'b000000, 6'b000111, 0, 0, 1'b0);
        add_instr(6'b000100, 6'b000000, 0, 0, 1'b0);
        add_instr(6'b001000, 6'b000000, 0, 0, 1'b0);
        add_instr(6'b001100, 6'b000000, 2, 0, 1'b0);
        add_instr(6'b001010, 6'b000000, 0, 0, 1'b0);
        add_instr(6'b100011, 6'b000000, 1, 1, 1'b0);
        add_instr(6'b111111, 6'b000000, 0, 0, 1'b0);
        add_instr(6'b100011, 6'b000000, 0, 2, 1'b1);
        add_instr(6'b001000, 6'b000000, 0, 0, 1'b0);

        while (vq.size() > 0) begin
            v = vq.pop_front();
            @(negedge clk);
            reset       = v.rst;
            i_mem_ready = v.rdy;
            i_opcode    = v.op;
            i_function  = v.fn;
            #2;
            act = '{mem_req: o_mem_req, mem_wr_en: o_mem_wr_en, addr_sel: o_mem_addr_sel,
                    instr_wr_en: o_instr_wr_en, pc_en: o_pc_en, branch: o_branch,
                    branch_ne: o_branch_ne, pc_next_sel: o_pc_next_sel, src_a: o_alu_src_a_sel,
                    src_b: o_alu_src_b_sel, zext: o_imm_zero_ext, alu: o_alu_cntrl,
                    reg_wr_en: o_reg_wr_en, wr_addr_sel: o_reg_wr_addr_sel,
                    wr_data_sel: o_reg_wr_data_sel, retire: o_instr_retire,
`ifdef CTRL_ILLEGAL_TRAP_EN
                    trap: o_trap};
`else
                    trap: 1'b0};
`endif
            if (o_instr_retire) n_retire++;
            n_vec++;
            if (act !== v.exp) begin
                n_miss++;
                $display("FAIL ctl vec%0d instr%0d rst=%b rdy=%b: got %b want %b (mreq,mwr,asel,irwr,pcen,beq,bne,pcsel2,srca,srcb2,zext,alu3,rwr,rdst,rmdr,ret,trap)",
                         n_vec, v.id, v.rst, v.rdy, act, v.exp);
            end
        end

        n_vec++;
        if (n_retire != 17) begin
            n_miss++;
            $display("FAIL retire_count: got %0d want 17", n_retire);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
